// File: rtl/alarm_clock_display.sv
// -----------------------------------------------------------------------------
// alarm_clock_display
//
// Hardware time-of-day and alarm engine. A prescaler divides clk_clk down to
// a one-second tick. The tick advances an hh:mm:ss register, which drives six
// registered 7-segment digits. An alarm register (hh:mm, seconds implied 00)
// is compared against the time once per second. A ring/snooze state machine
// drives the LED bank. The state machine is acknowledged by a debounced
// active-low key.
//
// Ports
//   clk_clk            system clock
//   reset_reset        asynchronous, active-high reset
//   button_export      raw alarm-acknowledge key, active-low, asynchronous
//   set_valid          one-cycle load strobe
//   set_target         0 = load time, 1 = load alarm
//   set_hours          load value, hours 0-23
//   set_minutes        load value, minutes 0-59
//   set_seconds        load value, seconds 0-59 (time loads only)
//   alarm_enable       level; 0 disarms the alarm and forces IDLE
//   set_error          one-cycle pulse after a rejected load
//   ringing            high while the alarm is ringing
//   leds_export        alarm indication (flashing while ringing, bit 0 in snooze)
//   segment1..6_export {dp,g,f,e,d,c,b,a} for ss ones/tens, mm ones/tens,
//                      hh ones/tens; dp of digits 3 and 5 shows alarm_enable
// -----------------------------------------------------------------------------
module alarm_clock_display #(
  parameter int TICKS_PER_SEC   = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_SECONDS  = 300,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int NUM_LEDS        = 10
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                button_export,
  input  logic                set_valid,
  input  logic                set_target,
  input  logic [4:0]          set_hours,
  input  logic [5:0]          set_minutes,
  input  logic [5:0]          set_seconds,
  input  logic                alarm_enable,
  output logic                set_error,
  output logic                ringing,
  output logic [NUM_LEDS-1:0] leds_export,
  output logic [7:0]          segment1_export,
  output logic [7:0]          segment2_export,
  output logic [7:0]          segment3_export,
  output logic [7:0]          segment4_export,
  output logic [7:0]          segment5_export,
  output logic [7:0]          segment6_export
);

  localparam int PW   = $clog2(TICKS_PER_SEC);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRE_LAST    = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF    = PW'(TICKS_PER_SEC / 2);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_FULL    = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] RING_LAST   = TW'(RING_SECONDS - 1);
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SECONDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Display helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] dec_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] dec_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Segment pattern with lit = 1, flipped to the board polarity on return.
  function automatic logic [7:0] seg_code(input logic [3:0] digit, input logic dp);
    logic [6:0] lit;
    case (digit)
      4'd0:    lit = 7'h3F;
      4'd1:    lit = 7'h06;
      4'd2:    lit = 7'h5B;
      4'd3:    lit = 7'h4F;
      4'd4:    lit = 7'h66;
      4'd5:    lit = 7'h6D;
      4'd6:    lit = 7'h7D;
      4'd7:    lit = 7'h07;
      4'd8:    lit = 7'h7F;
      4'd9:    lit = 7'h6F;
      default: lit = 7'h00;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~{dp, lit} : {dp, lit};
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_p0;
  logic          tick;
  logic          tick_eff;
  logic          tick_p1;

  logic [4:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [4:0]    alarm_hours;
  logic [5:0]    alarm_minutes;

  logic          load_ok;
  logic          time_load;
  logic          alarm_load;
  logic          alarm_match;

  logic          btn_meta;
  logic          btn_sync;
  logic [DW-1:0] low_cnt;
  logic          press;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  // ---------------------------------------------------------------------------
  // Stage p0: prescaler and load decode
  // ---------------------------------------------------------------------------
  assign tick    = (pre_p0 == PRE_LAST);
  assign load_ok = (set_hours <= 5'd23) && (set_minutes <= 6'd59) &&
                   (set_target || (set_seconds <= 6'd59));
  assign time_load  = set_valid && load_ok && !set_target;
  assign alarm_load = set_valid && load_ok && set_target;
  // A time load restarts the second, so a tick in the same cycle is dropped.
  assign tick_eff   = tick && !time_load;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pre_p0 <= '0;
    end else if (time_load || tick) begin
      pre_p0 <= '0;
    end else begin
      pre_p0 <= pre_p0 + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: time, alarm and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (time_load) begin
      hours   <= set_hours;
      minutes <= set_minutes;
      seconds <= set_seconds;
    end else if (tick) begin
      if (seconds == 6'd59) begin
        seconds <= '0;
        if (minutes == 6'd59) begin
          minutes <= '0;
          hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      set_error     <= 1'b0;
      tick_p1       <= 1'b0;
    end else begin
      if (alarm_load) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end
      set_error <= set_valid && !load_ok;
      // Remembers that the time just advanced by a real second, so only an
      // exact-second arrival (never a load jumping onto the alarm) can ring.
      tick_p1   <= tick_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: registered 7-segment outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      segment1_export <= seg_code(4'd0, 1'b0);
      segment2_export <= seg_code(4'd0, 1'b0);
      segment3_export <= seg_code(4'd0, 1'b0);
      segment4_export <= seg_code(4'd0, 1'b0);
      segment5_export <= seg_code(4'd0, 1'b0);
      segment6_export <= seg_code(4'd0, 1'b0);
    end else begin
      segment1_export <= seg_code(dec_ones(seconds), 1'b0);
      segment2_export <= seg_code(dec_tens(seconds), 1'b0);
      segment3_export <= seg_code(dec_ones(minutes), alarm_enable);
      segment4_export <= seg_code(dec_tens(minutes), 1'b0);
      segment5_export <= seg_code(dec_ones({1'b0, hours}), alarm_enable);
      segment6_export <= seg_code(dec_tens({1'b0, hours}), 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Button: synchroniser and stable-low debounce
  // ---------------------------------------------------------------------------
  // low_cnt saturates at DEBOUNCE_CYCLES, so a held key yields one pulse and
  // only a high sample re-arms it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      low_cnt  <= '0;
      press    <= 1'b0;
    end else begin
      btn_meta <= button_export;
      btn_sync <= btn_meta;
      if (btn_sync) begin
        low_cnt <= '0;
        press   <= 1'b0;
      end else if (low_cnt != DEB_FULL) begin
        low_cnt <= low_cnt + DW'(1);
        press   <= (low_cnt == DEB_LAST);
      end else begin
        press   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm state machine
  // ---------------------------------------------------------------------------
  assign alarm_match = (seconds == 6'd0) && (hours == alarm_hours) &&
                       (minutes == alarm_minutes);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    if (!alarm_enable) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_p1 && alarm_match) begin
            state_next = RINGING;
            timer_next = '0;
          end
        end
        RINGING: begin
          if (press) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (tick_eff) begin
            if (timer == RING_LAST) begin
              state_next = SNOOZE;
              timer_next = '0;
            end else begin
              timer_next = timer + TW'(1);
            end
          end
        end
        SNOOZE: begin
          if (press) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (tick_eff) begin
            if (timer == SNOOZE_LAST) begin
              state_next = RINGING;
              timer_next = '0;
            end else begin
              timer_next = timer + TW'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  assign ringing = (state == RINGING);

  // LEDs flash with the prescaler phase: on for the first half of each second.
  always_comb begin
    leds_export = '0;
    case (state)
      RINGING: if (pre_p0 < PRE_HALF) leds_export = '1;
      SNOOZE:  leds_export[0] = 1'b1;
      default: leds_export = '0;
    endcase
  end

endmodule

// File: tb/tb_alarm_clock_display.sv
module tb_alarm_clock_display;

  localparam int T  = 4;
  localparam int D  = 3;
  localparam int RS = 2;
  localparam int SS = 3;
  localparam int NL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          button_export;
  logic          set_valid;
  logic          set_target;
  logic [4:0]    set_hours;
  logic [5:0]    set_minutes;
  logic [5:0]    set_seconds;
  logic          alarm_enable;
  logic          set_error;
  logic          ringing;
  logic [NL-1:0] leds_export;
  logic [7:0]    seg1, seg2, seg3, seg4, seg5, seg6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_clock_display #(
    .TICKS_PER_SEC(T), .DEBOUNCE_CYCLES(D), .RING_SECONDS(RS),
    .SNOOZE_SECONDS(SS), .SEG_ACTIVE_LOW(1), .NUM_LEDS(NL)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .button_export(button_export),
    .set_valid(set_valid), .set_target(set_target), .set_hours(set_hours),
    .set_minutes(set_minutes), .set_seconds(set_seconds),
    .alarm_enable(alarm_enable), .set_error(set_error), .ringing(ringing),
    .leds_export(leds_export),
    .segment1_export(seg1), .segment2_export(seg2), .segment3_export(seg3),
    .segment4_export(seg4), .segment5_export(seg5), .segment6_export(seg6)
  );

  // ---------------- behavioural reference model ----------------
  // Time and alarm are seconds-of-day integers; mode 0 idle, 1 ring, 2 snooze.
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int  m_tod, m_pre, m_alarm, m_mode, m_secs, m_low;
  bit  m_s1, m_s2, m_press, m_err, m_tickap;
  logic [7:0] m_seg [6];

  function automatic logic [7:0] seg_of(input int d, input bit dp);
    logic [7:0] v;
    v = {dp, pat[d]};
    return ~v;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int  h, mi, s;
    bit  tick, ok, tload, aload, teff;
    if (rst) begin
      m_tod = 0; m_pre = 0; m_alarm = 0; m_mode = 0; m_secs = 0; m_low = 0;
      m_s1 = 1; m_s2 = 1; m_press = 0; m_err = 0; m_tickap = 0;
      for (int i = 0; i < 6; i++) m_seg[i] = seg_of(0, 0);
    end else begin
      tick  = (m_pre == T - 1);
      ok    = (set_hours <= 23) && (set_minutes <= 59) &&
              (set_target || set_seconds <= 59);
      tload = set_valid && ok && !set_target;
      aload = set_valid && ok && set_target;
      teff  = tick && !tload;
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      s  = m_tod % 60;
      m_seg[0] = seg_of(s % 10, 0);
      m_seg[1] = seg_of(s / 10, 0);
      m_seg[2] = seg_of(mi % 10, alarm_enable);
      m_seg[3] = seg_of(mi / 10, 0);
      m_seg[4] = seg_of(h % 10, alarm_enable);
      m_seg[5] = seg_of(h / 10, 0);
      if (!alarm_enable) m_mode = 0;
      else if (m_mode == 0) begin
        if (m_tickap && m_tod == m_alarm) begin m_mode = 1; m_secs = 0; end
      end else if (m_press) m_mode = 0;
      else if (teff) begin
        m_secs++;
        if (m_mode == 1 && m_secs == RS) begin m_mode = 2; m_secs = 0; end
        else if (m_mode == 2 && m_secs == SS) begin m_mode = 1; m_secs = 0; end
      end
      m_tickap = teff;
      m_err    = set_valid && !ok;
      if (tload) begin
        m_tod = set_hours * 3600 + set_minutes * 60 + set_seconds;
        m_pre = 0;
      end else if (tick) begin
        m_tod = (m_tod + 1) % 86400;
        m_pre = 0;
      end else m_pre++;
      if (aload) m_alarm = set_hours * 3600 + set_minutes * 60;
      // press fires on the D-th consecutive low synchronised sample
      m_press = !m_s2 && (m_low + 1 == D);
      if (m_s2) m_low = 0;
      else if (m_low < 1000) m_low++;
      m_s2 = m_s1;
      m_s1 = button_export;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0]    dseg [6];
    logic [NL-1:0] exp_leds;
    dseg = '{seg1, seg2, seg3, seg4, seg5, seg6};
    if (m_mode == 1) exp_leds = (m_pre < T / 2) ? '1 : '0;
    else if (m_mode == 2) exp_leds = NL'(1);
    else exp_leds = '0;
    check_eq("set_error", set_error, m_err);
    check_eq("ringing", ringing, m_mode == 1);
    check_eq("leds", leds_export, exp_leds);
    for (int i = 0; i < 6; i++) check_eq($sformatf("segment%0d", i + 1), dseg[i], m_seg[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg1"}, seg1, 8'hC0);
    check_eq({tag, "_seg2"}, seg2, 8'hC0);
    check_eq({tag, "_seg3"}, seg3, 8'hC0);
    check_eq({tag, "_seg4"}, seg4, 8'hC0);
    check_eq({tag, "_seg5"}, seg5, 8'hC0);
    check_eq({tag, "_seg6"}, seg6, 8'hC0);
    check_eq({tag, "_leds"}, leds_export, '0);
    check_eq({tag, "_ringing"}, ringing, 1'b0);
    check_eq({tag, "_set_error"}, set_error, 1'b0);
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic load_time(input int h, input int m, input int s);
    set_target = 0; set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
    set_valid = 1;
    tick_cycles(1);
    set_valid = 0;
  endtask

  task automatic load_alarm(input int h, input int m);
    set_target = 1; set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 0;
    set_valid = 1;
    tick_cycles(1);
    set_valid = 0;
  endtask

  task automatic wait_level(input string tag, input logic lvl, input int exp_k);
    int k;
    for (k = 1; k <= 40; k++) begin
      tick_cycles(1);
      if (ringing === lvl) break;
    end
    check_eq(tag, k, exp_k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, t, btn_left;
    rst = 1; button_export = 1; set_valid = 0; set_target = 0;
    set_hours = 0; set_minutes = 0; set_seconds = 0; alarm_enable = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // first second after reset
    tick_cycles(5);
    check_eq("first_sec_seg1", seg1, 8'hF9);
    check_eq("first_sec_seg2", seg2, 8'hC0);

    // midnight wrap
    load_time(23, 59, 59);
    tick_cycles(5);
    check_reset_outputs("wrap");

    // rejected loads
    set_target = 0; set_hours = 24; set_minutes = 0; set_seconds = 0; set_valid = 1;
    tick_cycles(1);
    set_valid = 0;
    check_eq("err_hours24", set_error, 1'b1);
    tick_cycles(1);
    check_eq("err_hours24_clear", set_error, 1'b0);
    set_target = 1; set_hours = 1; set_minutes = 60; set_valid = 1;
    tick_cycles(1);
    set_valid = 0;
    check_eq("err_min60_alarm", set_error, 1'b1);
    tick_cycles(1);
    check_eq("err_min60_clear", set_error, 1'b0);

    // load coincident with a tick: loaded value is not incremented
    for (int i = 0; i < 8 && m_pre != T - 1; i++) tick_cycles(1);
    load_time(10, 20, 30);
    tick_cycles(1);
    check_eq("load_tick_seg1", seg1, 8'hC0);
    check_eq("load_tick_seg2", seg2, 8'hB0);

    // alarm ring, snooze, ring again
    alarm_enable = 1;
    load_alarm(0, 1);
    load_time(0, 0, 58);
    wait_level("ring_latency", 1'b1, 9);
    check_eq("ring_leds_on", leds_export, 10'h3FF);
    tick_cycles(1);
    check_eq("ring_leds_off", leds_export, 10'h000);
    wait_level("ring_length", 1'b0, 6);
    check_eq("snooze_leds", leds_export, 10'h001);
    wait_level("snooze_length", 1'b1, 12);

    // short glitch does not acknowledge
    button_export = 0; tick_cycles(2);
    button_export = 1; tick_cycles(4);
    check_eq("glitch_no_ack", ringing, 1'b1);
    // real press acknowledges
    button_export = 0; tick_cycles(5);
    button_export = 1; tick_cycles(3);
    check_eq("press_idle_ringing", ringing, 1'b0);
    check_eq("press_idle_leds", leds_export, '0);

    // key held through the next alarm
    button_export = 0; tick_cycles(8);
    load_alarm(0, 6);
    load_time(0, 5, 58);
    wait_level("hold_ring_latency", 1'b1, 9);
    tick_cycles(3);
    check_eq("hold_no_ack", ringing, 1'b1);
    button_export = 1; tick_cycles(1);
    button_export = 0; tick_cycles(6);
    button_export = 1; tick_cycles(3);
    check_eq("reack_idle_ringing", ringing, 1'b0);
    check_eq("reack_idle_leds", leds_export, '0);

    // disarm while ringing
    load_alarm(0, 8);
    load_time(0, 7, 58);
    wait_level("dis_ring_latency", 1'b1, 9);
    alarm_enable = 0;
    tick_cycles(1);
    check_eq("disarm_ringing", ringing, 1'b0);
    check_eq("disarm_leds", leds_export, '0);
    alarm_enable = 1;

    // asynchronous reset mid-ring
    load_alarm(0, 10);
    load_time(0, 9, 58);
    wait_level("rst_ring_latency", 1'b1, 9);
    #2 rst = 1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    compare_all();
    rst = 0;

    // randomized traffic against the model
    btn_left = 0;
    for (int i = 0; i < 1500; i++) begin
      set_valid = 0;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        set_target  = 1'($urandom_range(0, 1));
        set_hours   = 5'($urandom_range(0, 26));
        set_minutes = 6'($urandom_range(0, 62));
        set_seconds = 6'($urandom_range(0, 62));
        set_valid   = 1;
      end else if (r < 7) begin
        t = (m_alarm - $urandom_range(1, 3) + 86400) % 86400;
        set_target  = 0;
        set_hours   = 5'(t / 3600);
        set_minutes = 6'((t / 60) % 60);
        set_seconds = 6'(t % 60);
        set_valid   = 1;
      end
      if (alarm_enable ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
        alarm_enable = ~alarm_enable;
      if (btn_left == 0) begin
        button_export = ($urandom_range(0, 2) != 0);
        btn_left = $urandom_range(1, 9);
      end
      btn_left--;
      tick_cycles(1);
    end
    set_valid = 0;
    tick_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
